// File: rtl/ddrphy_wr_path.sv
// rtl/ddrphy_wr_path.sv - DFI write-data path to DDR output cells with DQS preamble/postamble
//
// Delays DFI write data by WR_DELAY cycles and sequences the DQ/DQS pad
// enables: IDLE -> PRE (preamble) -> DATA (one clk per rise/fall beat pair)
// -> POST (postamble) -> IDLE/PRE/DATA.
//
// Parameters:
//   WR_DELAY  cycles from dfi_wrdata_en sample to first data on outputs (2..8)
//   BL        DRAM burst length (4 or 8); a burst spans BL/2 clk cycles
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   dfi_wrdata_en             DFI write data valid (tphy_wrdata = 0)
//   dfi_wrdata[127:0]         [127:64] rising beat, [63:0] falling beat
//   dfi_wrdata_mask[15:0]     [15:8] rising, [7:0] falling byte masks (1 = not written)
//   dq_rise/dq_fall[63:0]     beat data to the DDR output cell (0 while dq_oe = 0)
//   dm_rise/dm_fall[7:0]      byte masks to the DDR output cell
//   dqs_rise/dqs_fall[7:0]    strobe levels to the DDR output cell
//   dq_oe, dqs_oe             pad output enables for DQ/DM and DQS/DQS_n
//   wr_err                    sticky: a write burst ended off a BL/2 boundary
// Configuration:
//   DDRPHY_WR_DM_EN           when defined, data masks are pipelined and driven
//                             during DATA; otherwise dm_rise = dm_fall = 0.
module ddrphy_wr_path #(
    parameter int WR_DELAY = 3,
    parameter int BL       = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         dfi_wrdata_en,
    input  logic [127:0] dfi_wrdata,
    input  logic [15:0]  dfi_wrdata_mask,
    output logic [63:0]  dq_rise,
    output logic [63:0]  dq_fall,
    output logic [7:0]   dm_rise,
    output logic [7:0]   dm_fall,
    output logic [7:0]   dqs_rise,
    output logic [7:0]   dqs_fall,
    output logic         dq_oe,
    output logic         dqs_oe,
    output logic         wr_err
);

    localparam int HALF = BL / 2;
    localparam int CW   = $clog2(HALF);
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

    typedef enum logic [1:0] {IDLE, PRE, DATA, POST} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WR_DELAY-1:0] en_pipe;
    logic [127:0]        data_pipe [WR_DELAY];
    logic [CW-1:0]       beat_cnt;

    // Last stage feeds the pads; the one before it tells the FSM a cycle early
    // that data is coming so the preamble can be placed in front of it.
    logic         look_en;
    logic         out_en;
    logic [127:0] out_data;
    assign look_en  = en_pipe[WR_DELAY-2];
    assign out_en   = en_pipe[WR_DELAY-1];
    assign out_data = data_pipe[WR_DELAY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_pipe <= '0;
            for (int i = 0; i < WR_DELAY; i++) data_pipe[i] <= '0;
        end else begin
            en_pipe      <= {en_pipe[WR_DELAY-2:0], dfi_wrdata_en};
            data_pipe[0] <= dfi_wrdata;
            for (int i = 1; i < WR_DELAY; i++) data_pipe[i] <= data_pipe[i-1];
        end
    end

`ifdef DDRPHY_WR_DM_EN
    logic [15:0] mask_pipe [WR_DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WR_DELAY; i++) mask_pipe[i] <= '0;
            dm_rise <= '0;
            dm_fall <= '0;
        end else begin
            mask_pipe[0] <= dfi_wrdata_mask;
            for (int i = 1; i < WR_DELAY; i++) mask_pipe[i] <= mask_pipe[i-1];
            if (state_nxt == DATA) begin
                dm_rise <= mask_pipe[WR_DELAY-1][15:8];
                dm_fall <= mask_pipe[WR_DELAY-1][7:0];
            end else begin
                dm_rise <= '0;
                dm_fall <= '0;
            end
        end
    end
`else
    logic unused_mask;
    assign unused_mask = ^dfi_wrdata_mask;
    assign dm_rise     = '0;
    assign dm_fall     = '0;
`endif

    // DDR2 strobes are low in pre/postamble and only toggle in DATA, where
    // the falling half of every clk is always 0.
    assign dqs_fall = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (look_en) state_nxt = PRE;
            PRE:  state_nxt = DATA;
            DATA: if (!out_en) state_nxt = POST;
            // A single idle cycle between bursts: the postamble doubles as
            // the next preamble, so go straight back to DATA.
            POST: begin
                if (out_en)       state_nxt = DATA;
                else if (look_en) state_nxt = PRE;
                else              state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_oe    <= 1'b0;
            dqs_oe   <= 1'b0;
            dqs_rise <= '0;
            dq_rise  <= '0;
            dq_fall  <= '0;
            beat_cnt <= '0;
            wr_err   <= 1'b0;
        end else begin
            dq_oe    <= (state_nxt == DATA);
            dqs_oe   <= (state_nxt != IDLE);
            dqs_rise <= {8{state_nxt == DATA}};
            if (state_nxt == DATA) begin
                dq_rise  <= out_data[127:64];
                dq_fall  <= out_data[63:0];
                beat_cnt <= (state == DATA) ? beat_cnt + 1'b1 : '0;
            end else begin
                dq_rise  <= '0;
                dq_fall  <= '0;
            end
            if (state == DATA && state_nxt != DATA && beat_cnt != CNT_LAST)
                wr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddrphy_wr_path.sv
// tb/tb_ddrphy_wr_path.sv - scoreboard bench for ddrphy_wr_path against a pad-timeline model
module tb_ddrphy_wr_path;

    localparam int W    = 3;
    localparam int BL   = 4;
    localparam int HALF = BL / 2;

    typedef logic [162:0] obs_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         dfi_wrdata_en = 1'b0;
    logic [127:0] dfi_wrdata = '0;
    logic [15:0]  dfi_wrdata_mask = '0;
    logic [63:0]  dq_rise, dq_fall;
    logic [7:0]   dm_rise, dm_fall, dqs_rise, dqs_fall;
    logic         dq_oe, dqs_oe, wr_err;

    always #5 clk = ~clk;

    ddrphy_wr_path #(.WR_DELAY(W), .BL(BL)) dut (
        .clk(clk), .rst_n(rst_n),
        .dfi_wrdata_en(dfi_wrdata_en), .dfi_wrdata(dfi_wrdata), .dfi_wrdata_mask(dfi_wrdata_mask),
        .dq_rise(dq_rise), .dq_fall(dq_fall), .dm_rise(dm_rise), .dm_fall(dm_fall),
        .dqs_rise(dqs_rise), .dqs_fall(dqs_fall), .dq_oe(dq_oe), .dqs_oe(dqs_oe), .wr_err(wr_err)
    );

    int   vectors = 0;
    int   miscompares = 0;
    logic err_model = 1'b0;

    logic         sq_en[$];
    logic [127:0] sq_data[$];
    logic [15:0]  sq_mask[$];
    obs_t         exp_q[$];

    function automatic obs_t observed();
        return {dq_oe, dqs_oe, dqs_rise, dqs_fall, dm_rise, dm_fall, wr_err, dq_rise, dq_fall};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic push_cycle(input logic en, input logic [127:0] d, input logic [15:0] m);
        sq_en.push_back(en);
        sq_data.push_back(d);
        sq_mask.push_back(m);
    endtask

    task automatic push_burst(input int len, input int gap_before);
        for (int i = 0; i < gap_before; i++) push_cycle(1'b0, '0, '0);
        for (int i = 0; i < len; i++) push_cycle(1'b1, rand128(), 16'($urandom()));
    endtask

    // Pad-side view: cycle c carries data iff en was driven W+1 cycles earlier.
    function automatic logic d_at(input int c);
        int idx = c - W - 1;
        if (idx >= 0 && idx < sq_en.size()) return sq_en[idx];
        return 1'b0;
    endfunction

    task automatic run_seq(input string name);
        int len;
        for (int i = 0; i < W + 3; i++) push_cycle(1'b0, '0, '0);
        len = sq_en.size();
        @(negedge clk);
        fork
            begin
                int run_len = 0;
                for (int c = 0; c < len; c++) begin
                    logic dc, dp, dn;
                    logic [127:0] dat;
                    logic [15:0]  msk;
                    logic [7:0]   dmr, dmf;
                    @(posedge clk);
                    #1;
                    dfi_wrdata_en   = sq_en[c];
                    dfi_wrdata      = sq_data[c];
                    dfi_wrdata_mask = sq_mask[c];
                    dc = d_at(c);
                    dp = d_at(c - 1);
                    dn = d_at(c + 1);
                    if (dp && !dc && (run_len % HALF) != 0) err_model = 1'b1;
                    if (dc) run_len = dp ? run_len + 1 : 1;
                    dat = dc ? sq_data[c - W - 1] : '0;
                    msk = dc ? sq_mask[c - W - 1] : '0;
`ifdef DDRPHY_WR_DM_EN
                    dmr = msk[15:8];
                    dmf = msk[7:0];
`else
                    dmr = 8'h00;
                    dmf = 8'h00;
`endif
                    exp_q.push_back({dc, dp | dc | dn, dc ? 8'hFF : 8'h00, 8'h00, dmr, dmf,
                                     err_model, dat[127:64], dat[63:0]});
                end
            end
            begin
                for (int c = 0; c < len; c++) begin
                    @(negedge clk);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL %s cycle %0d no expected entry", name, c);
                    end else begin
                        check($sformatf("%s_c%0d", name, c), observed(), exp_q.pop_front());
                    end
                end
            end
        join
        sq_en.delete();
        sq_data.delete();
        sq_mask.delete();
    endtask

    initial begin
        #12;
        check("reset_state", observed(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single BL4 burst with fixed pattern
        push_cycle(1'b0, '0, '0);
        push_cycle(1'b1, {{16{4'hA}}, {16{4'h5}}}, 16'h00FF);
        push_cycle(1'b1, {{16{4'h5}}, {16{4'hA}}}, 16'h00FF);
        run_seq("single");

        push_burst(4, 2);                       run_seq("back2back");
        push_burst(2, 2); push_burst(2, 1);     run_seq("gap1");
        push_burst(2, 1); push_burst(4, 2);     run_seq("gap2");

        for (int b = 0; b < 40; b++) push_burst(HALF * $urandom_range(1, 3), $urandom_range(1, 4));
        run_seq("random_ok");

        // Odd-length enable run sets the sticky error; valid bursts follow.
        push_burst(3, 2); push_burst(2, 3); push_burst(4, 1);
        run_seq("odd_len");

        for (int b = 0; b < 30; b++)
            push_burst(HALF * $urandom_range(1, 3) + ($urandom_range(0, 7) == 0 ? 1 : 0),
                       $urandom_range(1, 4));
        run_seq("random_mix");

        // Reset during the second DATA cycle of a burst
        begin
            bit seen = 0;
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                #1;
                dfi_wrdata_en = 1'b1;
                dfi_wrdata    = rand128();
            end
            @(posedge clk);
            #1;
            dfi_wrdata_en = 1'b0;
            dfi_wrdata    = '0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = dq_oe;
            end
            if (!seen) begin
                vectors++;
                miscompares++;
                $display("FAIL mid_reset_wait dq_oe never rose within 20 cycles");
            end
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            check("mid_reset_async", observed(), '0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                check($sformatf("post_reset_idle_c%0d", i), observed(), '0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
